frame_decoder_n: RTL and testbench
==================================

# frame_decoder_n

Synchronous, parametrised successor to the fixed two-channel symbol decoder. It accepts a frame of one-hot symbols over six four-phase rails (Fs, Fe, Fd, X0, One, Zero) and acknowledges each one. The frame carries a multi-bit signed-magnitude command per channel for `N_CH` channels. It sits between the serial symbol link and the channel actuators, and presents the up/down/magnitude commands of the last good frame.

## Interface
- `N_CH`, default 2: number of channel fields per frame (1..16).
- `W`, default 4: symbols per channel field (2..16). MSB is direction (1 = up); the remaining `W-1` bits are magnitude, MSB first.

- `clk`  in  1  single clock; all rails are synchronous to it.
- `rst_n`  in  1  asynchronous active-low reset.
- `Fs`, `Fe`, `Fd`, `X0`, `One`, `Zero`  in  1 each  symbol rails: frame start, frame end, frame discard, channel separator, data 1, data 0.
- `Fs_ack`, `Fe_ack`, `Fd_ack`, `X0_ack`, `one_ack`, `zero_ack`  out  1 each  four-phase acknowledges.
- `ch_up`  out  `N_CH`  per-channel up command (level).
- `ch_down`  out  `N_CH`  per-channel down command (level).
- `ch_mag`  out  `N_CH*(W-1)`  per-channel magnitude; channel c is at `[c*(W-1) +: W-1]`.
- `frame_valid`  out  1  one-cycle pulse when the outputs update.
- `frame_err`  out  1  one-cycle pulse on any protocol error.

## Operation
- **Accept rule:** a symbol is accepted in a cycle where the global ack-busy flag is low and at least one rail is high.
  - On accept, the ack of each high rail rises on the next edge.
  - Each ack holds while its rail is high and falls on the edge after the rail falls.
  - Busy clears when all acks are low.
- **Multiple rails high in the accept cycle:** all of them are acknowledged; the event is treated as a protocol error.
- **FSM states:**
  - `IDLE`: Fs → `FIELD` (channel=0, bit=0); any other symbol → error.
  - `FIELD`: One/Zero shifts into the field register and increments bit. At bit `W-1`, the field is stored to the shadow of the current channel and the FSM goes to `SEP`. X0, Fe or Fs here → error.
  - `SEP`: X0 with channel < `N_CH-1` → channel+1, `FIELD`. Fe with channel = `N_CH-1` → commit, `IDLE`. Any other symbol → error.
- **Fd in any state:** discard shadow, go to `IDLE`, no error, no commit.
- **Fs in `FIELD` or `SEP`:** `frame_err` pulses and the decoder restarts the frame (channel=0, bit=0, state `FIELD`).
- **Error (other cases):** `frame_err` pulses, shadow discarded, state `IDLE`. Outputs keep the last committed frame.
- **Commit:** the shadow is copied to the output registers.
  - `ch_up[c]` = dir & (mag != 0).
  - `ch_down[c]` = ~dir & (mag != 0).
  - `ch_mag` = mag.
  - Zero magnitude gives both up and down low.
- **Reset:** all outputs and acks are 0, state `IDLE`. Reset mid-frame discards the frame with no error pulse.

## Timing
- Symbol accepted in cycle k: ack is high from k+1.
- Rail dropped in cycle j: ack is low at j+1.
- Maximum rate is one symbol per 2 cycles (rail held exactly one cycle).
- The Fe accept cycle is k. `ch_*` and the one-cycle `frame_valid` pulse appear at k+1.
- `frame_err` pulses at k+1 after the offending accept.
- Rails held high for many cycles produce exactly one accept.

## Structure
- Package `frame_decoder_pkg`:
  - state enum (`IDLE`, `FIELD`, `SEP`);
  - one-hot symbol index constants (`SYM_FS`..`SYM_ZERO`, 6 bits);
  - function `popcount6` for multi-rail detection.
- Sub-module `sym_handshake`:
  - owns the six ack flops and the busy flag;
  - outputs a one-cycle `sym_stb` plus the 6-bit one-hot `sym` and a `multi` flag.
- The top level holds the FSM, field shift register, shadow array and output registers.

## Test plan
- N_CH=2, W=4. Fs, 1,0,1,1, X0, 0,0,1,0, Fe, rails one cycle each with 1-cycle gaps:
  - `ch_up`=01, `ch_down`=10, `ch_mag`=6'b010_011;
  - `frame_valid` is 1 for exactly one cycle, one cycle after the Fe accept.
- Frame Fs, 1000, X0, 0000, Fe: `ch_up`=00, `ch_down`=00, `ch_mag`=0, `frame_valid` pulses.
- After the first frame, send Fs, 1,1 then Fd:
  - `Fd_ack` completes, no `frame_valid`, no `frame_err`;
  - outputs still 01/10/010_011.
- Fs, 1011, Fe (early end): `frame_err` pulses once, outputs unchanged, next legal frame commits normally.
- One and Zero raised in the same cycle during `FIELD`:
  - both acks rise next cycle and fall after their rails;
  - `frame_err` pulses, state `IDLE`.
- Assert `rst_n`=0 mid-field with `one_ack` high:
  - acks and all outputs go 0 immediately;
  - after release, a full legal frame decodes correctly.

Source files
------------

// File: rtl/frame_decoder_pkg.sv
// Shared types, symbol encodings and helpers for the frame decoder.
package frame_decoder_pkg;

    // Decoder FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIELD = 2'd1,
        SEP   = 2'd2
    } state_e;

    // One-hot symbol positions in the 6-bit rail vector.
    localparam logic [5:0] SYM_FS   = 6'b000001;
    localparam logic [5:0] SYM_FE   = 6'b000010;
    localparam logic [5:0] SYM_FD   = 6'b000100;
    localparam logic [5:0] SYM_X0   = 6'b001000;
    localparam logic [5:0] SYM_ONE  = 6'b010000;
    localparam logic [5:0] SYM_ZERO = 6'b100000;

    // Number of rails high; more than one in an accept cycle is an error.
    function automatic logic [2:0] popcount6(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/frame_decoder_n_if.sv
// Symbol link and channel command bundle between the link side and the decoder.
//
// Handshake: four-phase. A rail rising while no ack is outstanding is one
// symbol; its ack rises the next cycle, stays high while the rail stays high,
// and falls the cycle after the rail falls. No new symbol is taken until every
// ack is low again.
interface frame_decoder_n_if #(
    parameter int N_CH = 2,
    parameter int W    = 4
);
    logic                      Fs, Fe, Fd, X0, One, Zero;
    logic                      Fs_ack, Fe_ack, Fd_ack, X0_ack, one_ack, zero_ack;
    logic [N_CH-1:0]           ch_up;
    logic [N_CH-1:0]           ch_down;
    logic [N_CH*(W-1)-1:0]     ch_mag;
    logic                      frame_valid;
    logic                      frame_err;

    // Link side: drives rails, observes acks and commands.
    modport master (
        output Fs, Fe, Fd, X0, One, Zero,
        input  Fs_ack, Fe_ack, Fd_ack, X0_ack, one_ack, zero_ack,
        input  ch_up, ch_down, ch_mag, frame_valid, frame_err
    );

    // Decoder side.
    modport slave (
        input  Fs, Fe, Fd, X0, One, Zero,
        output Fs_ack, Fe_ack, Fd_ack, X0_ack, one_ack, zero_ack,
        output ch_up, ch_down, ch_mag, frame_valid, frame_err
    );
endinterface

// File: rtl/frame_decoder_n_sym_handshake.sv
// Four-phase acknowledge for the six symbol rails; emits one strobe per symbol.
module sym_handshake
    import frame_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] rails_i,
    output logic [5:0] ack_o,
    output logic       sym_stb_o,
    output logic [5:0] sym_o,
    output logic       multi_o
);
    logic [5:0] ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       accept;

    // A symbol is taken only when no ack is outstanding.
    assign accept    = !busy_q && (rails_i != 6'b0);
    assign sym_stb_o = accept;
    assign sym_o     = rails_i;
    assign multi_o   = popcount6(rails_i) > 3'd1;
    assign ack_o     = ack_q;

    // Acks latch the accepted rails, then track each rail until it drops.
    always_comb begin
        ack_d  = accept ? rails_i : (ack_q & rails_i);
        busy_d = |ack_d;
    end

    // Ack and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 6'b0;
            busy_q <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: rtl/frame_decoder_n.sv
// Frame decoder: assembles per-channel signed-magnitude fields from the symbol
// stream and publishes them as up/down/magnitude commands on a good frame end.
module frame_decoder_n
    import frame_decoder_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    frame_decoder_n_if.slave  bus,
    output state_e            state_o
);
    localparam int BW = $clog2(W);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int MW = N_CH * (W - 1);

    logic [5:0] rails, acks, sym;
    logic       sym_stb, multi;
    logic       is_fs, is_fe, is_fd, is_x0, is_one, is_zero;

    state_e                    state_q, state_d;
    logic [CW-1:0]             chan_q, chan_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [W-1:0]              field_q, field_d;
    logic [N_CH-1:0][W-1:0]    shadow_q, shadow_d;
    logic [N_CH-1:0]           up_q, up_d, down_q, down_d;
    logic [MW-1:0]             mag_q, mag_d;
    logic                      valid_q, valid_d, err_q, err_d;

    assign rails = {bus.Zero, bus.One, bus.X0, bus.Fd, bus.Fe, bus.Fs};

    sym_handshake u_hs (
        .clk       (clk),
        .rst_n     (rst_n),
        .rails_i   (rails),
        .ack_o     (acks),
        .sym_stb_o (sym_stb),
        .sym_o     (sym),
        .multi_o   (multi)
    );

    assign {bus.zero_ack, bus.one_ack, bus.X0_ack, bus.Fd_ack, bus.Fe_ack, bus.Fs_ack} = acks;

    assign is_fs   = |(sym & SYM_FS);
    assign is_fe   = |(sym & SYM_FE);
    assign is_fd   = |(sym & SYM_FD);
    assign is_x0   = |(sym & SYM_X0);
    assign is_one  = |(sym & SYM_ONE);
    assign is_zero = |(sym & SYM_ZERO);

    assign bus.ch_up       = up_q;
    assign bus.ch_down     = down_q;
    assign bus.ch_mag      = mag_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_err   = err_q;
    assign state_o         = state_q;

    // Frame FSM: next state, field assembly, shadow capture and commit.
    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        bit_d    = bit_q;
        field_d  = field_q;
        shadow_d = shadow_q;
        up_d     = up_q;
        down_d   = down_q;
        mag_d    = mag_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (sym_stb) begin
            if (multi) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else if (is_fd) begin
                // Discard is silent; the shadow is simply never committed.
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (is_fs) begin
                            state_d = FIELD;
                            chan_d  = '0;
                            bit_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    FIELD: begin
                        if (is_one || is_zero) begin
                            field_d = {field_q[W-2:0], is_one};
                            if (bit_q == BW'(W - 1)) begin
                                shadow_d[chan_q] = field_d;
                                state_d          = SEP;
                            end else begin
                                bit_d = bit_q + BW'(1);
                            end
                        end else if (is_fs) begin
                            // A fresh start mid-frame restarts from channel 0.
                            err_d   = 1'b1;
                            state_d = FIELD;
                            chan_d  = '0;
                            bit_d   = '0;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    SEP: begin
                        if (is_x0 && (chan_q != CW'(N_CH - 1))) begin
                            chan_d  = chan_q + CW'(1);
                            bit_d   = '0;
                            state_d = FIELD;
                        end else if (is_fe && (chan_q == CW'(N_CH - 1))) begin
                            for (int c = 0; c < N_CH; c++) begin
                                up_d[c]   =  shadow_q[c][W-1] & (|shadow_q[c][W-2:0]);
                                down_d[c] = ~shadow_q[c][W-1] & (|shadow_q[c][W-2:0]);
                                mag_d[c*(W-1) +: W-1] = shadow_q[c][W-2:0];
                            end
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else if (is_fs) begin
                            err_d   = 1'b1;
                            state_d = FIELD;
                            chan_d  = '0;
                            bit_d   = '0;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            chan_q   <= '0;
            bit_q    <= '0;
            field_q  <= '0;
            shadow_q <= '0;
            up_q     <= '0;
            down_q   <= '0;
            mag_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            bit_q    <= bit_d;
            field_q  <= field_d;
            shadow_q <= shadow_d;
            up_q     <= up_d;
            down_q   <= down_d;
            mag_q    <= mag_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_frame_decoder_n.sv
// Directed bench for frame_decoder_n with N_CH=2, W=4.
module tb_frame_decoder_n;
    import frame_decoder_pkg::*;

    localparam int N_CH = 2;
    localparam int W    = 4;

    logic   clk;
    logic   rst_n;
    state_e dbg_state;

    int n_vec;
    int n_err;
    int v_cnt, e_cnt;
    logic v_first, e_first;

    frame_decoder_n_if #(.N_CH(N_CH), .W(W)) bus ();

    frame_decoder_n #(.N_CH(N_CH), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_rails(input logic [5:0] s);
        {bus.Zero, bus.One, bus.X0, bus.Fd, bus.Fe, bus.Fs} = s;
    endtask

    function automatic logic [5:0] get_acks();
        return {bus.zero_ack, bus.one_ack, bus.X0_ack, bus.Fd_ack, bus.Fe_ack, bus.Fs_ack};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise s at a falling edge for 'hold' cycles, then drop it for one cycle.
    // Records frame_valid/frame_err seen one cycle after the accept and the
    // total number of cycles each was high during the symbol.
    task automatic send(input logic [5:0] s, input int hold);
        v_cnt = 0;
        e_cnt = 0;
        @(negedge clk);
        set_rails(s);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 0) begin
                v_first = bus.frame_valid;
                e_first = bus.frame_err;
            end
            v_cnt += int'(bus.frame_valid);
            e_cnt += int'(bus.frame_err);
            check("ack_high", 32'(get_acks()), 32'(s));
        end
        set_rails(6'b0);
        @(negedge clk);
        v_cnt += int'(bus.frame_valid);
        e_cnt += int'(bus.frame_err);
        check("ack_low", 32'(get_acks()), 32'h0);
    endtask

    task automatic send_field(input logic [3:0] f);
        for (int i = 3; i >= 0; i--) begin
            send(f[i] ? SYM_ONE : SYM_ZERO, 1);
            check("field_err", 32'(e_cnt), 32'h0);
        end
    endtask

    task automatic send_frame(input logic [3:0] f0, input logic [3:0] f1);
        send(SYM_FS, 1);
        send_field(f0);
        send(SYM_X0, 1);
        send_field(f1);
        send(SYM_FE, 1);
    endtask

    task automatic check_outs(input string tag, input logic [1:0] up, input logic [1:0] dn,
                              input logic [5:0] mag);
        check({tag, "_up"},   32'(bus.ch_up),   32'(up));
        check({tag, "_down"}, 32'(bus.ch_down), 32'(dn));
        check({tag, "_mag"},  32'(bus.ch_mag),  32'(mag));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        v_cnt = 0;
        e_cnt = 0;
        v_first = 1'b0;
        e_first = 1'b0;
        set_rails(6'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_acks", 32'(get_acks()), 32'h0);
        check_outs("rst", 2'b00, 2'b00, 6'b0);
        check("rst_valid", 32'(bus.frame_valid), 32'h0);
        check("rst_err", 32'(bus.frame_err), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1; Fs held 4 cycles must count as one symbol
        send(SYM_FS, 4);
        check("hold_err", 32'(e_cnt), 32'h0);
        check("hold_state", 32'(dbg_state), 32'(FIELD));
        send_field(4'b1011);
        send(SYM_X0, 1);
        send_field(4'b0010);
        check_outs("pre_f1", 2'b00, 2'b00, 6'b0);
        send(SYM_FE, 1);
        check("f1_valid_first", 32'(v_first), 32'h1);
        check("f1_valid_cnt", 32'(v_cnt), 32'h1);
        check("f1_err", 32'(e_cnt), 32'h0);
        check_outs("f1", 2'b01, 2'b10, 6'b010_011);
        check("f1_state", 32'(dbg_state), 32'(IDLE));

        // Discard mid-frame
        send(SYM_FS, 1);
        send(SYM_ONE, 1);
        send(SYM_ONE, 1);
        send(SYM_FD, 1);
        check("fd_valid", 32'(v_cnt), 32'h0);
        check("fd_err", 32'(e_cnt), 32'h0);
        check("fd_state", 32'(dbg_state), 32'(IDLE));
        check_outs("fd", 2'b01, 2'b10, 6'b010_011);

        // Early end after one channel
        send(SYM_FS, 1);
        send_field(4'b1011);
        send(SYM_FE, 1);
        check("early_err_first", 32'(e_first), 32'h1);
        check("early_err_cnt", 32'(e_cnt), 32'h1);
        check("early_valid", 32'(v_cnt), 32'h0);
        check("early_state", 32'(dbg_state), 32'(IDLE));
        check_outs("early", 2'b01, 2'b10, 6'b010_011);

        // Frame 2: zero magnitudes clear both directions
        send_frame(4'b1000, 4'b0000);
        check("f2_valid_first", 32'(v_first), 32'h1);
        check("f2_valid_cnt", 32'(v_cnt), 32'h1);
        check("f2_err", 32'(e_cnt), 32'h0);
        check_outs("f2", 2'b00, 2'b00, 6'b0);

        // Fs in SEP restarts the frame with an error pulse
        send(SYM_FS, 1);
        send_field(4'b0001);
        send(SYM_FS, 1);
        check("restart_err", 32'(e_cnt), 32'h1);
        check("restart_state", 32'(dbg_state), 32'(FIELD));
        send_field(4'b1111);
        send(SYM_X0, 1);
        send_field(4'b0100);
        send(SYM_FE, 1);
        check("restart_valid", 32'(v_cnt), 32'h1);
        check_outs("restart", 2'b01, 2'b10, 6'b100_111);

        // One and Zero together in FIELD
        send(SYM_FS, 1);
        send(SYM_ONE, 1);
        send(SYM_ONE | SYM_ZERO, 1);
        check("multi_err_first", 32'(e_first), 32'h1);
        check("multi_err_cnt", 32'(e_cnt), 32'h1);
        check("multi_state", 32'(dbg_state), 32'(IDLE));
        check_outs("multi", 2'b01, 2'b10, 6'b100_111);

        // Symbol in IDLE other than Fs is an error
        send(SYM_X0, 1);
        check("idle_x0_err", 32'(e_cnt), 32'h1);

        // Reset mid-field with one_ack high
        send_frame(4'b1011, 4'b0010);
        check_outs("pre_rst", 2'b01, 2'b10, 6'b010_011);
        send(SYM_FS, 1);
        send(SYM_ONE, 1);
        @(negedge clk);
        set_rails(SYM_ONE);
        @(negedge clk);
        check("mid_one_ack", 32'(bus.one_ack), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_acks", 32'(get_acks()), 32'h0);
        check_outs("mid_rst", 2'b00, 2'b00, 6'b0);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        set_rails(6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_err", 32'(bus.frame_err), 32'h0);

        // Full frame after reset: ch0 0101 (down 5), ch1 1111 (up 7)
        send_frame(4'b0101, 4'b1111);
        check("f3_valid_first", 32'(v_first), 32'h1);
        check("f3_valid_cnt", 32'(v_cnt), 32'h1);
        check("f3_err", 32'(e_cnt), 32'h0);
        check_outs("f3", 2'b10, 2'b01, 6'b111_101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
